// File: rtl/uart_async_rx_pkg.sv
// Shared types and constants for the 16x-oversampled UART receiver.
// Includes the frame-state encoding, the sample-tick positions and a majority-vote helper.
package uart_async_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_BIT9  = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  localparam int         OVERSAMPLE     = 16;
  localparam logic [3:0] SAMPLE_A       = 4'd7;
  localparam logic [3:0] SAMPLE_B       = 4'd8;
  localparam logic [3:0] SAMPLE_C       = 4'd9;
  localparam logic [3:0] STOP_EVAL_TICK = 4'd9;
  localparam logic [3:0] LAST_TICK      = 4'(OVERSAMPLE - 1);

  typedef struct packed {
    logic       ferr;
    logic       rx9d;
    logic [7:0] data;
  } rx_frame_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_async_rx_fifo.sv
// Two-entry RCREG FIFO holding {ferr, rx9d, data}; the head reads as zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_async_rx_fifo
  import uart_async_rx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rx_frame_t wdata,
  input  logic      pop,
  output rx_frame_t rdata,
  output logic      full,
  output logic      empty
);

  rx_frame_t  mem_q [2];
  rx_frame_t  mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push_s, do_pop_s;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = empty ? rx_frame_t'(10'd0) : mem_q[rd_ptr_q];

  // Pointer, count and storage update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_async_rx.sv
// PIC16F-style asynchronous UART receiver: synchroniser, 16x tick/bit counters,
// 3-sample majority voter, frame FSM, overrun flag and a 2-deep RCREG FIFO.
module uart_async_rx
  import uart_async_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RXD,
  input  logic       sample_en,
  input  logic       rx9,
  input  logic       cren,
  input  logic       aden,
  input  logic       rcreg_rd_en,
  output logic [7:0] rcreg_out,
  output logic       rx9d_out,
  output logic       ferr_out,
  output logic       oerr,
  output logic       rxif_set_en,
  output logic       rx_busy
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e              state_q, state_d;
  logic [3:0]             tick_q, tick_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             samp_q, samp_d;
  logic [8:0]             rsr_q, rsr_d;
  logic                   push_q, push_d;
  rx_frame_t              frame_q, frame_d;
  logic                   oerr_q, oerr_d;
  rx_frame_t              head_s;
  logic                   rxd_s, fifo_full_s, fifo_empty_s, pop_ok_s;
  logic                   bit_maj_s, stop_maj_s;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], UART_RXD};
  assign rxd_s      = sync_q[SYNC_STAGES-1];
  assign bit_maj_s  = majority3(samp_q[0], samp_q[1], samp_q[2]);
  // The stop bit is judged on the tick-9 strobe itself, so its third vote is the live input.
  assign stop_maj_s = majority3(samp_q[0], samp_q[1], rxd_s);
  assign pop_ok_s   = rcreg_rd_en & ~fifo_empty_s;

  // Next-state, sampling, shift register and overrun logic.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    samp_d    = samp_q;
    rsr_d     = rsr_q;
    push_d    = 1'b0;
    frame_d   = frame_q;
    oerr_d    = oerr_q;

    if (sample_en && (state_q != ST_IDLE)) begin
      case (tick_q)
        SAMPLE_A: samp_d[0] = rxd_s;
        SAMPLE_B: samp_d[1] = rxd_s;
        SAMPLE_C: samp_d[2] = rxd_s;
        default:  samp_d    = samp_q;
      endcase
    end else begin
      samp_d = samp_q;
    end

    if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s && !oerr_q) begin
            state_d = ST_START;
            tick_d  = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_q == LAST_TICK) begin
            tick_d = 4'd0;
            if (!bit_maj_s) begin
              state_d   = ST_DATA;
              bit_cnt_d = 3'd0;
              rsr_d     = 9'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (tick_q == LAST_TICK) begin
            tick_d = 4'd0;
            rsr_d  = {rsr_q[8], bit_maj_s, rsr_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d = rx9 ? ST_BIT9 : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        ST_BIT9: begin
          if (tick_q == LAST_TICK) begin
            tick_d   = 4'd0;
            rsr_d[8] = bit_maj_s;
            state_d  = ST_STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (tick_q == STOP_EVAL_TICK) begin
            tick_d       = 4'd0;
            state_d      = ST_IDLE;
            push_d       = ~(aden & rx9 & ~rsr_q[8]);
            frame_d.ferr = ~stop_maj_s;
            frame_d.rx9d = rx9 & rsr_q[8];
            frame_d.data = rsr_q[7:0];
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (push_q && fifo_full_s && !pop_ok_s) begin
      oerr_d = 1'b1;
    end else begin
      oerr_d = oerr_q;
    end

    // Disabling reception clears the overrun; an active overrun parks the FSM.
    if (!cren) begin
      state_d   = ST_IDLE;
      tick_d    = 4'd0;
      bit_cnt_d = 3'd0;
      push_d    = 1'b0;
      oerr_d    = 1'b0;
    end else if (oerr_q) begin
      state_d   = ST_IDLE;
      tick_d    = 4'd0;
      bit_cnt_d = 3'd0;
    end else begin
      oerr_d = oerr_d;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= ST_IDLE;
      tick_q    <= 4'd0;
      bit_cnt_q <= 3'd0;
      samp_q    <= 3'd0;
      rsr_q     <= 9'd0;
      push_q    <= 1'b0;
      frame_q   <= '0;
      oerr_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      samp_q    <= samp_d;
      rsr_q     <= rsr_d;
      push_q    <= push_d;
      frame_q   <= frame_d;
      oerr_q    <= oerr_d;
    end
  end

  uart_async_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (frame_q),
    .pop   (rcreg_rd_en),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign rcreg_out   = head_s.data;
  assign rx9d_out    = head_s.rx9d;
  assign ferr_out    = head_s.ferr;
  assign oerr        = oerr_q;
  assign rxif_set_en = ~fifo_empty_s;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_async_rx.sv
// Directed bench for uart_async_rx: sample_en every 4 clocks, 64 clocks per serial bit.
// Observed vector layout: {rcreg_out[7:0], rx9d_out, ferr_out, rxif_set_en, oerr}.
module tb_uart_async_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst, UART_RXD, sample_en, rx9, cren, aden, rcreg_rd_en;
  logic [7:0] rcreg_out;
  logic       rx9d_out, ferr_out, oerr, rxif_set_en, rx_busy;
  logic [11:0] obs;
  int checks = 0;
  int errors = 0;

  assign obs = {rcreg_out, rx9d_out, ferr_out, rxif_set_en, oerr};

  always #5 clk = ~clk;

  uart_async_rx dut (
    .clk         (clk),
    .rst         (rst),
    .UART_RXD    (UART_RXD),
    .sample_en   (sample_en),
    .rx9         (rx9),
    .cren        (cren),
    .aden        (aden),
    .rcreg_rd_en (rcreg_rd_en),
    .rcreg_out   (rcreg_out),
    .rx9d_out    (rx9d_out),
    .ferr_out    (ferr_out),
    .oerr        (oerr),
    .rxif_set_en (rxif_set_en),
    .rx_busy     (rx_busy)
  );

  initial begin
    sample_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
    end
  end

  task automatic drive_bit(input logic v);
    UART_RXD = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use9, input logic nin,
                            input logic stopv, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use9) drive_bit(nin);
    drive_bit(stopv);
    UART_RXD = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rd_pulse();
    rcreg_rd_en = 1'b1;
    @(negedge clk);
    rcreg_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; UART_RXD = 1'b1; rx9 = 1'b0; cren = 1'b1; aden = 1'b0; rcreg_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs, rx_busy} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", {obs, rx_busy}, 13'd0);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16);
    checks++;
    if (obs !== {8'hA5, 4'b0010}) begin
      errors++; $display("FAIL basic_a5: got %h expected %h", obs, {8'hA5, 4'b0010});
    end
    rd_pulse();
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL basic_pop_empty: got %h expected %h", obs, 12'h000);
    end
  endtask

  task automatic test_false_start();
    logic seen;
    seen = 1'b0;
    UART_RXD = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    UART_RXD = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL false_start_busy_seen: got %b expected %b", seen, 1'b1);
    end
    checks++;
    if ({obs, rx_busy} !== 13'd0) begin
      errors++; $display("FAIL false_start_idle: got %h expected %h", {obs, rx_busy}, 13'd0);
    end
  endtask

  task automatic test_ferr();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 150);
    checks++;
    if (obs !== {8'h3C, 4'b0110}) begin
      errors++; $display("FAIL ferr_3c: got %h expected %h", obs, {8'h3C, 4'b0110});
    end
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 16);
    rd_pulse();
    checks++;
    if (obs !== {8'h01, 4'b0010}) begin
      errors++; $display("FAIL ferr_next_clean: got %h expected %h", obs, {8'h01, 4'b0010});
    end
    rd_pulse();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 16);
    checks++;
    if (obs !== {8'h11, 4'b0011}) begin
      errors++; $display("FAIL overrun_set: got %h expected %h", obs, {8'h11, 4'b0011});
    end
    send_frame(8'h44, 1'b0, 1'b0, 1'b1, 16);
    checks++;
    if ({obs, rx_busy} !== {8'h11, 4'b0011, 1'b0}) begin
      errors++; $display("FAIL overrun_ignore_44: got %h expected %h", {obs, rx_busy}, {8'h11, 4'b0011, 1'b0});
    end
    rd_pulse();
    checks++;
    if (obs !== {8'h22, 4'b0011}) begin
      errors++; $display("FAIL overrun_second: got %h expected %h", obs, {8'h22, 4'b0011});
    end
    rd_pulse();
    checks++;
    if (obs !== {8'h00, 4'b0001}) begin
      errors++; $display("FAIL overrun_empty_sticky: got %h expected %h", obs, {8'h00, 4'b0001});
    end
    cren = 1'b0;
    repeat (4) @(negedge clk);
    cren = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL overrun_cleared: got %h expected %h", obs, 12'h000);
    end
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 16);
    checks++;
    if (obs !== {8'h55, 4'b0010}) begin
      errors++; $display("FAIL overrun_recover_55: got %h expected %h", obs, {8'h55, 4'b0010});
    end
    rd_pulse();
  endtask

  task automatic test_aden();
    rx9 = 1'b1; aden = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 16);
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL aden_drop: got %h expected %h", obs, 12'h000);
    end
    send_frame(8'h80, 1'b1, 1'b1, 1'b1, 16);
    checks++;
    if (obs !== {8'h80, 4'b1010}) begin
      errors++; $display("FAIL aden_addr_80: got %h expected %h", obs, {8'h80, 4'b1010});
    end
    rd_pulse();
    rx9 = 1'b0; aden = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic found;
    found = 1'b0;
    send_frame(8'h61, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h62, 1'b0, 1'b0, 1'b1, 16);
    fork
      send_frame(8'h66, 1'b0, 1'b0, 1'b1, 16);
      begin
        for (int i = 0; i < 1200; i++) begin
          @(negedge clk);
          if (!found && dut.push_q) begin
            found = 1'b1;
            rcreg_rd_en = 1'b1;
            @(negedge clk);
            rcreg_rd_en = 1'b0;
          end
        end
      end
    join
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL b2b_push_timeout: got %b expected %b", found, 1'b1);
    end
    checks++;
    if (obs !== {8'h62, 4'b0010}) begin
      errors++; $display("FAIL b2b_head_62: got %h expected %h", obs, {8'h62, 4'b0010});
    end
    rd_pulse();
    checks++;
    if (obs !== {8'h66, 4'b0010}) begin
      errors++; $display("FAIL b2b_head_66: got %h expected %h", obs, {8'h66, 4'b0010});
    end
    rd_pulse();
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL b2b_empty: got %h expected %h", obs, 12'h000);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    checks++;
    if ({obs, rx_busy} !== {8'h5A, 4'b0010, 1'b1}) begin
      errors++; $display("FAIL midframe_busy: got %h expected %h", {obs, rx_busy}, {8'h5A, 4'b0010, 1'b1});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({obs, rx_busy} !== 13'd0) begin
      errors++; $display("FAIL midframe_reset: got %h expected %h", {obs, rx_busy}, 13'd0);
    end
    UART_RXD = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 16);
    checks++;
    if (obs !== {8'h7E, 4'b0010}) begin
      errors++; $display("FAIL after_reset_7e: got %h expected %h", obs, {8'h7E, 4'b0010});
    end
    rd_pulse();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_ferr();
    test_overrun();
    test_aden();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
